// File: rtl/layer_scheduler.sv
// Time-multiplexes one registered neuron datapath across the M neurons of a layer.
// Build option LAYER_SCHED_CFG_LOCK_EN: drop cfg writes while a vector is in flight.
module layer_scheduler #(
  parameter int N  = 2,
  parameter int M  = 4,
  parameter int QM = 3,
  parameter int QN = 5,
  parameter int WM = 6,
  parameter int WN = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [((M > 1) ? $clog2(M) : 1)-1:0] cfg_addr,
  input  logic [N*(WM+WN)-1:0] cfg_weights,
  input  logic [QM+QN-1:0]    cfg_bias,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*(QM+QN)-1:0] in_data,
  output logic [N*(QM+QN)-1:0] dp_in,
  output logic [N*(WM+WN)-1:0] dp_weights,
  output logic [QM+QN-1:0]    dp_bias,
  input  logic [QM+QN-1:0]    dp_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [M*(QM+QN)-1:0] out_data,
  output logic                busy
);

  localparam int AD = QM + QN;
  localparam int WD = WM + WN;
  localparam int AW = (M > 1) ? $clog2(M) : 1;
  localparam logic [AW-1:0] LAST = AW'(M - 1);
  localparam logic [AW:0]   M_L  = (AW + 1)'(M);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                    state;
  logic [AW-1:0]             idx;
  logic [AW-1:0]             cap_idx;
  logic                      cap_vld;
  logic [N*AD-1:0]           in_reg;
  logic [M-1:0][AD-1:0]      res;
  logic [M-1:0][N*WD-1:0]    wt;
  logic [M-1:0][AD-1:0]      bs;
  logic                      cfg_open;

`ifdef LAYER_SCHED_CFG_LOCK_EN
  assign cfg_open = !busy;
`else
  assign cfg_open = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wt <= '0;
      bs <= '0;
    end else if (cfg_we && cfg_open && ({1'b0, cfg_addr} < M_L)) begin
      wt[cfg_addr] <= cfg_weights;
      bs[cfg_addr] <= cfg_bias;
    end
  end

  assign dp_in      = in_reg;
  assign dp_weights = wt[idx];
  assign dp_bias    = bs[idx];
  assign out_data   = res;

  // Results trail issue by one cycle because the datapath output is registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      cap_idx   <= '0;
      cap_vld   <= 1'b0;
      in_reg    <= '0;
      res       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_reg   <= in_data;
            idx      <= '0;
            state    <= ISSUE;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ISSUE: begin
          if (cap_vld) res[cap_idx] <= dp_out;
          cap_idx <= idx;
          cap_vld <= 1'b1;
          if (idx == LAST) begin
            idx   <= '0;
            state <= DRAIN;
          end else begin
            idx <= idx + AW'(1);
          end
        end
        DRAIN: begin
          res[cap_idx] <= dp_out;
          state        <= DONE;
          out_valid    <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            cap_vld   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_scheduler.sv
// Directed bench for layer_scheduler with a behavioural Q3.5 x Q6.10 neuron datapath.
module tb_layer_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_weights;
  logic [7:0]  cfg_bias;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [15:0] dp_in;
  logic [31:0] dp_weights;
  logic [7:0]  dp_bias;
  logic [7:0]  dp_out;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int acc_q[$];
  logic [31:0] res_q[$];

  layer_scheduler #(.N(2), .M(4), .QM(3), .QN(5), .WM(6), .WN(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_weights(cfg_weights), .cfg_bias(cfg_bias),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .dp_in(dp_in), .dp_weights(dp_weights), .dp_bias(dp_bias), .dp_out(dp_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // MAC in Q9.15, truncate back to Q3.5, saturate, then ReLU.
  function automatic logic [7:0] neuron(input logic [15:0] x, input logic [31:0] w,
                                        input logic [7:0] b);
    longint acc;
    acc = longint'($signed(b)) <<< 10;
    for (int i = 0; i < 2; i++)
      acc += longint'($signed(x[i*8 +: 8])) * longint'($signed(w[i*16 +: 16]));
    acc = acc >>> 10;
    if (acc > 127)  acc = 127;
    if (acc < -128) acc = -128;
    if (acc < 0)    acc = 0;
    return acc[7:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dp_out <= '0;
    else        dp_out <= neuron(dp_in, dp_weights, dp_bias);
  end

  always @(posedge clk) begin
    if (in_valid && in_ready)   acc_q.push_back(cyc);
    if (out_valid && out_ready) res_q.push_back(out_data);
    cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] w, input logic [7:0] b);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_weights = w; cfg_bias = b;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic program_layer();
    cfg_write(2'd0, {16'h0400, 16'h0400}, 8'h00);
    cfg_write(2'd1, {16'h0000, 16'hFC00}, 8'h00);
    cfg_write(2'd2, {16'h7C00, 16'h7C00}, 8'h00);
    cfg_write(2'd3, 32'h0, 8'h08);
  endtask

  // Sends one vector; returns cycles from acceptance edge to out_valid.
  // With inject set, writes neuron 3 bias 0x10 at the second edge after acceptance.
  task automatic send(input logic [15:0] v, input bit inject, output int lat);
    int k;
    int cnt;
    @(negedge clk);
    in_data = v; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 30) begin
      @(negedge clk);
      k++;
    end
    if (k >= 30) check("tmo_accept", 0, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_data = 16'hA5A5;
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (inject && cnt == 1) begin
        cfg_we = 1'b1; cfg_addr = 2'd3; cfg_weights = 32'h0; cfg_bias = 8'h10;
      end else if (inject && cnt == 2) begin
        cfg_we = 1'b0;
      end
    end
    lat = cnt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int k;
    int n_acc;
    logic [31:0] held;
    logic [31:0] exp_n3;

    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_weights = '0; cfg_bias = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    check("rst_dp_bias", dp_bias, 0);
    rst_n = 1'b1;

    program_layer();
    check("cfg_dp_weights", dp_weights, 32'h04000400);

    // Basic vector: 1.0, 0.5
    out_ready = 1'b1;
    send(16'h1020, 1'b0, lat);
    check("lat_basic", lat, 5);
    check("res_basic", out_data, 32'h087F0030);
    @(negedge clk);
    check("idle_basic", in_ready, 1);

    // Backpressure with a second vector (2.0, 0.0)
    out_ready = 1'b0;
    send(16'h0040, 1'b0, lat);
    check("lat_bp", lat, 5);
    check("res_bp", out_data, 32'h087F0040);
    held = out_data;
    n_acc = acc_q.size();
    in_valid = 1'b1; in_data = 16'h1020;
    repeat (10) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
    end
    check("bp_stable", out_data, held);
    check("bp_valid_held", out_valid, 1);
    check("bp_no_accept", acc_q.size(), n_acc);
    out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("bp_release_ready", in_ready, 1);
    check("bp_release_valid", out_valid, 0);

    // Back-to-back
    acc_q.delete(); res_q.delete();
    in_data = 16'h1020; in_valid = 1'b1;
    k = 0;
    while (acc_q.size() < 1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    in_data = 16'h00F0;
    while (acc_q.size() < 2 && k < 40) begin
      @(negedge clk);
      k++;
    end
    in_valid = 1'b0;
    while (res_q.size() < 2 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) begin
      check("tmo_b2b", 0, 1);
    end else begin
      check("b2b_spacing", acc_q[1] - acc_q[0], 7);
      check("b2b_res0", res_q[0], 32'h087F0030);
      check("b2b_res1", res_q[1], 32'h08001000);
    end
    @(negedge clk);

    // Reset during the second ISSUE cycle
    in_data = 16'h1020; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_out_valid", out_valid, 0);
    check("mrst_in_ready", in_ready, 1);
    check("mrst_out_data", out_data, 0);
    check("mrst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(16'h1020, 1'b0, lat);
    check("mrst_lat", lat, 5);
    check("mrst_n3", out_data[31:24], 8'h00);
    check("mrst_all", out_data, 32'h0);
    @(negedge clk);

    // Config write to neuron 3 while the vector is in flight
`ifdef LAYER_SCHED_CFG_LOCK_EN
    exp_n3 = 32'h087F0030;
`else
    exp_n3 = 32'h107F0030;
`endif
    program_layer();
    send(16'h1020, 1'b1, lat);
    check("cfg_lat", lat, 5);
    check("cfg_inflight", out_data, exp_n3);
    @(negedge clk);
    send(16'h1020, 1'b0, lat);
    check("cfg_later", out_data, exp_n3);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
